// File: rtl/cla_pkg.sv
// cla_pkg
// Shared types and constants for the chunked carry-lookahead adder.
//   claState_e      : sequencer states (IDLE, RUN, DONE), 2-bit encoding
//   CLA_CHUNK       : bits handled by one lookahead slice per cycle
//   claChunkCount() : number of slice passes needed for a given operand width
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } claState_e;

    localparam int CLA_CHUNK = 4;

    function automatic int claChunkCount(input int width);
        return width / CLA_CHUNK;
    endfunction

endpackage

// File: rtl/cla4_slice.sv
// cla4_slice
// Purely combinational 4-bit carry-lookahead block.
// Ports:
//   p[4:1]  in   propagate terms (a ^ b) per bit
//   g[4:1]  in   generate terms (a & b) per bit
//   c0      in   carry into bit 1
//   c[4:1]  out  carry out of each bit position (c[4] is the chunk carry-out)
//   ps      out  group propagate for building a larger lookahead tree
//   gs      out  group generate for building a larger lookahead tree
// The chunk sum is formed by the user as p ^ {c[3:1], c0}.
module cla4_slice (
    input  logic [4:1] p,
    input  logic [4:1] g,
    input  logic       c0,
    output logic [4:1] c,
    output logic       ps,
    output logic       gs
);

    // Fully flattened lookahead equations: every carry depends only on
    // p, g and c0, so there is no ripple path through the slice.
    always_comb begin
        c[1] = g[1] | (p[1] & c0);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & c0);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & c0);
        c[4] = g[4] | (p[4] & g[3]) | (p[4] & p[3] & g[2])
             | (p[4] & p[3] & p[2] & g[1])
             | (p[4] & p[3] & p[2] & p[1] & c0);
        ps   = &p;
        gs   = g[4] | (p[4] & g[3]) | (p[4] & p[3] & g[2])
             | (p[4] & p[3] & p[2] & g[1]);
    end

endmodule

// File: rtl/cla_chunk_sequencer.sv
// cla_chunk_sequencer
// Multi-cycle WIDTH-bit adder that reuses a single 4-bit lookahead slice,
// one chunk per cycle starting at the LSB, carrying c4 between chunks.
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset (aborts any operation)
//   in_valid   in   operands a/b/cin valid
//   in_ready   out  high only in IDLE
//   a, b       in   WIDTH-bit operands
//   cin        in   carry into chunk 0
//   sub        in   (only with CLA_SEQ_SUB_EN) compute a-b instead of a+b
//   out_valid  out  high in DONE
//   out_ready  in   consumer accepts the result
//   sum        out  WIDTH-bit result
//   cout       out  carry out of the top chunk (for subtract: 1 = no borrow)
//   busy       out  high in RUN or DONE
// Optional feature macro: CLA_SEQ_SUB_EN adds the `sub` port.
module cla_chunk_sequencer
    import cla_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int N     = claChunkCount(WIDTH);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    if ((WIDTH % CLA_CHUNK) != 0 || WIDTH < CLA_CHUNK) begin : gWidthCheck
        $error("cla_chunk_sequencer: WIDTH must be a positive multiple of 4");
    end

    claState_e        state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic [CLA_CHUNK-1:0] aChunk;
    logic [CLA_CHUNK-1:0] bChunk;
    logic [4:1]           sliceP;
    logic [4:1]           sliceG;
    logic [4:1]           sliceC;
    logic [CLA_CHUNK-1:0] sliceSum;
    logic                 unusedPs;
    logic                 unusedGs;

    // Select the chunk addressed by the index and form propagate/generate.
    always_comb begin
        aChunk   = a_q[idx_q*CLA_CHUNK +: CLA_CHUNK];
        bChunk   = b_q[idx_q*CLA_CHUNK +: CLA_CHUNK];
        sliceP   = aChunk ^ bChunk;
        sliceG   = aChunk & bChunk;
        sliceSum = sliceP ^ {sliceC[3:1], carry_q};
    end

    cla4_slice uSlice (
        .p  (sliceP),
        .g  (sliceG),
        .c0 (carry_q),
        .c  (sliceC),
        .ps (unusedPs),
        .gs (unusedGs)
    );

    // Next-state and handshake outputs. Subtraction is folded into the
    // operand latch (b inverted, carry forced to 1) so RUN is add-only.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
`ifdef CLA_SEQ_SUB_EN
                    if (sub) begin
                        b_d     = ~b;
                        carry_d = 1'b1;
                    end
`endif
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                sum_d[idx_q*CLA_CHUNK +: CLA_CHUNK] = sliceSum;
                carry_d = sliceC[4];
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d  = sliceC[4];
                    state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
